// File: rtl/tc_hdd_ctrl.sv
// Request/response front-end for the TC HDD word store.
// Converts absolute addresses into a relative seek followed by a load or save.
module tc_hdd_ctrl #(
  parameter int unsigned DEPTH = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        rsp_valid,
  output logic        rsp_err,
  output logic [63:0] rsp_rdata,
  output logic [63:0] cur_pos,
  output logic [63:0] hdd_seek,
  output logic        hdd_load,
  output logic        hdd_save,
  output logic [63:0] hdd_in,
  input  logic [63:0] hdd_out
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEEK,
    S_ACCESS,
    S_RESP
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_write;
  logic        r_err;
  logic [63:0] r_addr;
  logic [63:0] r_wdata;
  logic [63:0] r_cur_pos;
  logic        r_rsp_valid;
  logic        r_rsp_err;
  logic [63:0] r_rsp_rdata;

  logic        w_accept;
  logic        w_oob;
  logic        w_same;

  assign w_accept = req_valid & req_ready;
  assign w_oob    = req_addr >= 64'(DEPTH);
  assign w_same   = req_addr == r_cur_pos;

  // ready is gated by rst so nothing is taken while the HDD pointer clears
  assign req_ready = (r_state == S_IDLE) & ~rst;

  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_err;
  assign rsp_rdata = r_rsp_rdata;
  assign cur_pos   = r_cur_pos;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_oob)       w_next = S_RESP;
          else if (w_same) w_next = S_ACCESS;
          else             w_next = S_SEEK;
        end
      end
      S_SEEK:   w_next = S_ACCESS;
      S_ACCESS: w_next = S_RESP;
      S_RESP:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    hdd_seek = '0;
    hdd_load = 1'b0;
    hdd_save = 1'b0;
    hdd_in   = '0;
    unique case (r_state)
      S_SEEK: hdd_seek = r_addr - r_cur_pos;
      S_ACCESS: begin
        hdd_load = ~r_write;
        hdd_save = r_write;
        hdd_in   = r_write ? r_wdata : 64'd0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_write     <= 1'b0;
      r_err       <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_cur_pos   <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_state     <= w_next;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      if (w_accept) begin
        r_write <= req_write;
        r_err   <= w_oob;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
      end
      if (r_state == S_SEEK) begin
        r_cur_pos <= r_addr;
      end
      // hdd_out already holds mem[r_addr] here for reads
      if (r_state == S_RESP) begin
        r_rsp_valid <= 1'b1;
        r_rsp_err   <= r_err;
        r_rsp_rdata <= (~r_write & ~r_err) ? hdd_out : 64'd0;
      end
    end
  end

endmodule
